instr_fetch_ctrl: RTL and testbench

//  Fetch sequencer and port arbiter in front of instruction_memory, which has one combinational read port indexed by word.

---
 rtl/ifetch_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 64 ++++++
 rtl/instr_fetch_ctrl.sv | 132 +++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package ifetch_pkg;

    // Canonical RISC-V NOP (addi x0, x0, 0), returned for out-of-range reads.
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic {
        RUN,
        HALTED
    } state_e;

    typedef enum logic {
        FETCH,
        DBG
    } req_e;

    // One fetched word as it travels through the queue.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO buffering fetched {pc, instr, fault} entries.
// Flush wins over push; the owner guarantees no push into a full queue
// and no pop from an empty one.
module fetch_queue
    import ifetch_pkg::*;
#(
    parameter int unsigned QDEPTH = 2,
    parameter int unsigned CNTW   = $clog2(QDEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  fq_entry_t       push_entry,
    input  logic            pop,
    input  logic            flush,
    output logic [CNTW-1:0] count,
    output logic            head_valid,
    output fq_entry_t       head
);

    localparam int unsigned PTRW = $clog2(QDEPTH);

    fq_entry_t       mem_q [QDEPTH];
    logic [PTRW-1:0] rd_ptr_q;
    logic [PTRW-1:0] wr_ptr_q;
    logic [CNTW-1:0] count_q;

    // Storage, pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + PTRW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTRW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Head view of the queue.
    always_comb begin
        count      = count_q;
        head_valid = (count_q != '0);
        head       = mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, arbitrates the single instruction memory
// read port between fetch and a debug requester, and delivers {pc, instr}
// to the datapath through a small queue.
module instr_fetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned QDEPTH     = 2,
    parameter int unsigned IMEM_WORDS = 501
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        out_fault,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt,
    input  logic        dbg_req,
    input  logic [63:0] dbg_addr,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata
);

    localparam int unsigned CNTW = $clog2(QDEPTH + 1);

    logic [63:0]     pc_q;
    state_e          state_q;
    req_e            rr_last_q;
    logic            dbg_rvalid_q;
    logic [31:0]     dbg_rdata_q;

    logic [CNTW-1:0] q_count;
    logic            pop;
    logic            fetch_req;
    logic            fetch_gnt;
    logic            contested;
    logic            fetch_fault;
    logic            dbg_oob;
    fq_entry_t       push_entry;
    fq_entry_t       head;

    assign pop = out_valid & out_ready;

    // A pop in the same cycle frees the slot, so a full queue can still accept a fetch.
    assign fetch_req = (state_q == RUN) & ~redirect_valid
                     & ((q_count < CNTW'(QDEPTH)) | pop);

    // Round-robin arbitration of the memory port and address mux.
    always_comb begin
        contested = fetch_req & dbg_req;
        if (contested) begin
            dbg_gnt = (rr_last_q == FETCH);
        end else begin
            dbg_gnt = dbg_req;
        end
        fetch_gnt = fetch_req & ~dbg_gnt;
        imem_addr = dbg_gnt ? dbg_addr : {2'b00, pc_q[63:2]};
    end

    // Build the queue entry for a fetch; out-of-range words become faulting NOPs.
    always_comb begin
        fetch_fault      = (pc_q[63:2] >= 62'(IMEM_WORDS));
        dbg_oob          = (dbg_addr >= 64'(IMEM_WORDS));
        push_entry.pc    = pc_q;
        push_entry.instr = fetch_fault ? NOP_INSTR : imem_data;
        push_entry.fault = fetch_fault;
    end

    // PC, run/halt FSM and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            state_q   <= RUN;
            rr_last_q <= DBG;
        end else begin
            if (redirect_valid) begin
                pc_q <= {redirect_pc[63:2], 2'b00};
            end else if (fetch_gnt) begin
                pc_q <= pc_q + 64'd4;
            end
            if (contested) begin
                rr_last_q <= dbg_gnt ? DBG : FETCH;
            end
            unique case (state_q)
                RUN:    if (halt)  state_q <= HALTED;
                HALTED: if (!halt) state_q <= RUN;
            endcase
        end
    end

    // Debug response: data captured on the grant edge, valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            dbg_rvalid_q <= dbg_gnt;
            if (dbg_gnt) begin
                dbg_rdata_q <= dbg_oob ? NOP_INSTR : imem_data;
            end
        end
    end

    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;

    fetch_queue #(
        .QDEPTH (QDEPTH),
        .CNTW   (CNTW)
    ) u_fetch_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fetch_gnt),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (q_count),
        .head_valid (out_valid),
        .head       (head)
    );

    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign out_fault = head.fault;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed, table-driven bench for instr_fetch_ctrl.
module tb_instr_fetch_ctrl;

    localparam int unsigned WORDS = 501;

    logic        clk;
    logic        rst_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_fault;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;
    logic        dbg_req;
    logic [63:0] dbg_addr;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;

    int total;
    int bad;

    typedef struct packed {
        logic        rdy;
        logic        hlt;
        logic        dreq;
        logic [63:0] daddr;
        logic        rv;
        logic [63:0] rpc;
        logic        vld;
        logic [63:0] opc;
        logic [31:0] ins;
        logic        flt;
        logic        gnt;
        logic [63:0] iaddr;
        logic        drv;
        logic [31:0] drd;
    } vec_t;

    vec_t vecs [29];

    instr_fetch_ctrl #(
        .RESET_PC   (64'h0),
        .QDEPTH     (2),
        .IMEM_WORDS (WORDS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_fault      (out_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .dbg_req        (dbg_req),
        .dbg_addr       (dbg_addr),
        .dbg_gnt        (dbg_gnt),
        .dbg_rvalid     (dbg_rvalid),
        .dbg_rdata      (dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: distinct word per index, word 15 is a jalr.
    function automatic logic [31:0] m(input int i);
        if (i == 15) return 32'h00040067;
        return 32'hC000_0000 + 32'(i);
    endfunction

    // Out-of-range reads return garbage so NOP substitution is visible.
    assign imem_data = (imem_addr < 64'(WORDS)) ? m(int'(imem_addr[31:0])) : 32'hDEAD_BEEF;

    function automatic vec_t v(input logic rdy, input logic hlt, input logic dreq,
                               input logic [63:0] daddr, input logic rv, input logic [63:0] rpc,
                               input logic vld, input logic [63:0] opc, input logic [31:0] ins,
                               input logic flt, input logic gnt, input logic [63:0] iaddr,
                               input logic drv, input logic [31:0] drd);
        vec_t t;
        t.rdy = rdy; t.hlt = hlt; t.dreq = dreq; t.daddr = daddr; t.rv = rv; t.rpc = rpc;
        t.vld = vld; t.opc = opc; t.ins = ins; t.flt = flt; t.gnt = gnt; t.iaddr = iaddr;
        t.drv = drv; t.drd = drd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        out_ready      = t.rdy;
        halt           = t.hlt;
        dbg_req        = t.dreq;
        dbg_addr       = t.daddr;
        redirect_valid = t.rv;
        redirect_pc    = t.rpc;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        out_ready = 1'b0; halt = 1'b0; dbg_req = 1'b0; dbg_addr = '0;
        redirect_valid = 1'b0; redirect_pc = '0;

        // Stream, backpressure, redirect, contested debug, fault, halt.
        vecs[0]  = v(1,0,0,0,0,0,     0,0,0,0,            0,0,   0,0);
        vecs[1]  = v(1,0,0,0,0,0,     1,'h0,m(0),0,       0,1,   0,0);
        vecs[2]  = v(1,0,0,0,0,0,     1,'h4,m(1),0,       0,2,   0,0);
        vecs[3]  = v(0,0,0,0,0,0,     1,'h8,m(2),0,       0,3,   0,0);
        vecs[4]  = v(0,0,0,0,0,0,     1,'h8,m(2),0,       0,4,   0,0);
        vecs[5]  = v(0,0,0,0,0,0,     1,'h8,m(2),0,       0,4,   0,0);
        vecs[6]  = v(0,0,0,0,0,0,     1,'h8,m(2),0,       0,4,   0,0);
        vecs[7]  = v(0,0,0,0,0,0,     1,'h8,m(2),0,       0,4,   0,0);
        vecs[8]  = v(0,0,0,0,0,0,     1,'h8,m(2),0,       0,4,   0,0);
        vecs[9]  = v(1,0,0,0,0,0,     1,'h8,m(2),0,       0,4,   0,0);
        vecs[10] = v(1,0,0,0,0,0,     1,'hC,m(3),0,       0,5,   0,0);
        vecs[11] = v(0,0,0,0,1,'h38,  1,'h10,m(4),0,      0,6,   0,0);
        vecs[12] = v(1,0,0,0,0,0,     0,0,0,0,            0,14,  0,0);
        vecs[13] = v(1,0,0,0,0,0,     1,'h38,m(14),0,     0,15,  0,0);
        vecs[14] = v(0,0,1,15,0,0,    1,'h3C,m(15),0,     0,16,  0,0);
        vecs[15] = v(1,0,1,15,0,0,    1,'h3C,m(15),0,     1,15,  0,0);
        vecs[16] = v(1,0,1,15,0,0,    1,'h40,m(16),0,     0,17,  1,32'h00040067);
        vecs[17] = v(1,0,0,0,0,0,     1,'h44,m(17),0,     0,18,  0,32'h00040067);
        vecs[18] = v(1,0,1,600,1,'h7D4, 1,'h48,m(18),0,   1,600, 0,32'h00040067);
        vecs[19] = v(1,0,0,0,0,0,     0,0,0,0,            0,501, 1,32'h13);
        vecs[20] = v(0,1,0,0,0,0,     1,'h7D4,32'h13,1,   0,502, 0,32'h13);
        vecs[21] = v(1,1,0,0,0,0,     1,'h7D4,32'h13,1,   0,503, 0,32'h13);
        vecs[22] = v(1,1,0,0,0,0,     1,'h7D8,32'h13,1,   0,503, 0,32'h13);
        vecs[23] = v(1,1,0,0,0,0,     0,0,0,0,            0,503, 0,32'h13);
        vecs[24] = v(1,1,0,0,1,'h13,  0,0,0,0,            0,503, 0,32'h13);
        vecs[25] = v(1,0,0,0,0,0,     0,0,0,0,            0,4,   0,32'h13);
        vecs[26] = v(1,0,0,0,0,0,     0,0,0,0,            0,4,   0,32'h13);
        vecs[27] = v(1,0,0,0,0,0,     1,'h10,m(4),0,      0,5,   0,32'h13);
        vecs[28] = v(1,0,1,3,0,0,     1,'h14,m(5),0,      1,3,   0,32'h13);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset dbg_rvalid", 64'(dbg_rvalid), 64'd0);
        chk("reset dbg_rdata", 64'(dbg_rdata), 64'd0);
        chk("reset imem_addr", imem_addr, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 29; k++) begin
            apply(vecs[k]);
            @(negedge clk);
            chk($sformatf("row%0d out_valid", k), 64'(out_valid), 64'(vecs[k].vld));
            if (vecs[k].vld) begin
                chk($sformatf("row%0d out_pc", k), out_pc, vecs[k].opc);
                chk($sformatf("row%0d out_instr", k), 64'(out_instr), 64'(vecs[k].ins));
                chk($sformatf("row%0d out_fault", k), 64'(out_fault), 64'(vecs[k].flt));
            end
            chk($sformatf("row%0d dbg_gnt", k), 64'(dbg_gnt), 64'(vecs[k].gnt));
            chk($sformatf("row%0d imem_addr", k), imem_addr, vecs[k].iaddr);
            chk($sformatf("row%0d dbg_rvalid", k), 64'(dbg_rvalid), 64'(vecs[k].drv));
            chk($sformatf("row%0d dbg_rdata", k), 64'(dbg_rdata), 64'(vecs[k].drd));
            @(posedge clk);
            #1;
        end

        // Debug response from the last row is live; reset must kill it immediately.
        dbg_req = 1'b0;
        chk("pre-reset dbg_rvalid", 64'(dbg_rvalid), 64'd1);
        chk("pre-reset dbg_rdata", 64'(dbg_rdata), 64'(m(3)));
        #1 rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 64'(out_valid), 64'd0);
        chk("async reset dbg_rvalid", 64'(dbg_rvalid), 64'd0);
        chk("async reset dbg_rdata", 64'(dbg_rdata), 64'd0);
        chk("async reset imem_addr", imem_addr, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("restart out_valid early", 64'(out_valid), 64'd0);
        chk("restart imem_addr", imem_addr, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("restart out_valid", 64'(out_valid), 64'd1);
        chk("restart out_pc", out_pc, 64'h0);
        chk("restart out_instr", 64'(out_instr), 64'(m(0)));
        @(posedge clk);
        @(negedge clk);
        chk("restart second out_pc", out_pc, 64'h4);
        chk("restart second out_instr", 64'(out_instr), 64'(m(1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
